// File: rtl/tt_weight_loader.sv
// Ternary weight loader: unpacks a byte stream of 2-bit weights into a packed
// InLen x OutLen weight array, masking inactive columns and illegal codes.
module tt_weight_loader #(
   parameter int InLen  = 16,
   parameter int OutLen = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_start,
   input  logic [6:0]                 ui_param,
   input  logic                       byte_valid,
   input  logic [7:0]                 byte_in,
   output logic                       byte_ready,
   output logic [2*InLen*OutLen-1:0]  W,
   output logic                       busy,
   output logic                       done,
   output logic                       w_valid,
   output logic                       enc_err
);

   localparam int NumW = InLen * OutLen;
   localparam int PtrW = $clog2(NumW) + 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t          state_reg;
   logic [PtrW-1:0] ptr_reg;
   logic [4:0]      rows_reg;
   logic [3:0]      cols_reg;
   logic [PtrW-1:0] total_w;
   logic [PtrW-1:0] ptr_next;
   logic [7:0]      filt_byte;
   logic            bad_code;

   assign total_w  = PtrW'(int'(rows_reg) * OutLen);
   assign ptr_next = ptr_reg + PtrW'(4);

   // Code 10 is illegal and always flagged; legal codes survive only in active columns.
   always_comb begin
      filt_byte = '0;
      bad_code  = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (byte_in[2*j +: 2] == 2'b10)
            bad_code = 1'b1;
         else if (((int'(ptr_reg) + j) % OutLen) < int'(cols_reg))
            filt_byte[2*j +: 2] = byte_in[2*j +: 2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         rows_reg   <= '0;
         cols_reg   <= '0;
         W          <= '0;
         byte_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         w_valid    <= 1'b0;
         enc_err    <= 1'b0;
      end else if (load_start) begin
         // Restart wins over any byte presented in the same cycle.
         state_reg  <= LOAD;
         ptr_reg    <= '0;
         rows_reg   <= {1'b0, ui_param[6:3] & 4'b1110} + 5'd2;
         cols_reg   <= {1'b0, ui_param[2:0]} + 4'd1;
         W          <= '0;
         byte_ready <= 1'b1;
         busy       <= 1'b1;
         done       <= 1'b0;
         w_valid    <= 1'b0;
         enc_err    <= 1'b0;
      end else begin
         case (state_reg)
            LOAD: begin
               if (byte_valid) begin
                  W[{ptr_reg, 1'b0} +: 8] <= filt_byte;
                  ptr_reg <= ptr_next;
                  if (bad_code)
                     enc_err <= 1'b1;
                  if (ptr_next == total_w) begin
                     state_reg  <= DONE;
                     done       <= 1'b1;
                     w_valid    <= 1'b1;
                     busy       <= 1'b0;
                     byte_ready <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done      <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_weight_loader.sv
// Randomized scoreboard bench for tt_weight_loader: expected weight arrays are
// queued at stimulus time and checked by a monitor on every done pulse.
module tb_tt_weight_loader;

   localparam int InLen  = 16;
   localparam int OutLen = 8;
   localparam int NumW   = InLen * OutLen;
   localparam int WBits  = 2 * NumW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load_start = 1'b0;
   logic [6:0]       ui_param = '0;
   logic             byte_valid = 1'b0;
   logic [7:0]       byte_in = '0;
   logic             byte_ready;
   logic [WBits-1:0] W;
   logic             busy;
   logic             done;
   logic             w_valid;
   logic             enc_err;

   tt_weight_loader #(.InLen(InLen), .OutLen(OutLen)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .ui_param(ui_param),
      .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
      .W(W), .busy(busy), .done(done), .w_valid(w_valid), .enc_err(enc_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WBits-1:0] w;
      logic             err;
   } exp_t;

   exp_t             sb_q[$];
   exp_t             mon_e;
   int               n_checks = 0;
   int               n_fail = 0;
   int               done_cnt = 0;

   // Reference model: one entry per weight index, plus load bookkeeping.
   logic [1:0]       wt[NumW];
   logic             m_err;
   int               m_ptr, m_rows, m_cols;
   logic [WBits-1:0] last_w;

   task automatic check(input string name, input logic [WBits-1:0] act, input logic [WBits-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [WBits-1:0] model_w();
      logic [WBits-1:0] r = '0;
      for (int k = 0; k < NumW; k++) r[2*k +: 2] = wt[k];
      return r;
   endfunction

   task automatic model_start(input logic [6:0] p);
      for (int k = 0; k < NumW; k++) wt[k] = 2'b00;
      m_err  = 1'b0;
      m_ptr  = 0;
      m_rows = (int'(p[6:3]) & 14) + 2;
      m_cols = int'(p[2:0]) + 1;
   endtask

   task automatic model_accept(input logic [7:0] b);
      for (int j = 0; j < 4; j++) begin
         int k = m_ptr + j;
         logic [1:0] code = b[2*j +: 2];
         if (code == 2'b10) m_err = 1'b1;
         else if ((k % OutLen) < m_cols) wt[k] = code;
      end
      m_ptr += 4;
   endtask

   function automatic logic [7:0] rand_byte(input bit allow_bad);
      logic [7:0] b;
      for (int j = 0; j < 4; j++) begin
         logic [1:0] c = 2'($urandom_range(0, 3));
         if (!allow_bad && c == 2'b10) c = 2'b11;
         b[2*j +: 2] = c;
      end
      return b;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 required no pending load");
         end else begin
            mon_e = sb_q.pop_front();
            check("done_W", W, mon_e.w);
            check("done_enc_err", WBits'(enc_err), WBits'(mon_e.err));
         end
      end
   end

   // Driver tasks are entered and left 1 time unit after a rising edge.
   task automatic start_load(input logic [6:0] p);
      load_start = 1'b1;
      ui_param   = p;
      byte_valid = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      @(posedge clk); #1;
      load_start = 1'b0;
      byte_valid = 1'b0;
      model_start(p);
      check("load_busy", WBits'(busy), WBits'(1'b1));
      check("load_ready", WBits'(byte_ready), WBits'(1'b1));
      check("load_cleared_W", W, '0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < g; i++) begin
         byte_in = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_in    = b;
      model_accept(b);
      if (m_ptr == m_rows * OutLen) sb_q.push_back('{w: model_w(), err: m_err});
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic run_load(input logic [6:0] p, input int first, input int fill, input int gap, input bit allow_bad);
      int n;
      logic [7:0] b;
      start_load(p);
      n = m_rows * OutLen / 4;
      for (int i = 0; i < n; i++) begin
         if (i == 0 && first >= 0) b = 8'(first);
         else if (fill >= 0) b = 8'(fill);
         else b = rand_byte(allow_bad);
         send_byte(b, gap);
      end
      check("end_done", WBits'(done), WBits'(1'b1));
      check("end_w_valid", WBits'(w_valid), WBits'(1'b1));
      check("end_busy", WBits'(busy), WBits'(1'b0));
      check("end_ready", WBits'(byte_ready), WBits'(1'b0));
      last_w = model_w();
      @(posedge clk); #1;
      check("done_pulse_end", WBits'(done), WBits'(1'b0));
      // Bytes offered while idle must be ignored.
      byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         byte_in = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      check("idle_hold_W", W, last_w);
      check("idle_w_valid", WBits'(w_valid), WBits'(1'b1));
      check("idle_enc_err", WBits'(enc_err), WBits'(m_err));
   endtask

   initial begin
      int done_before;
      repeat (2) @(posedge clk);
      #1;
      check("reset_W", W, '0);
      check("reset_outs", WBits'({byte_ready, busy, done, w_valid, enc_err}), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_load(7'b0000_111, -1, 8'h5D, 0, 1'b0);
      check("req031_w", WBits'(W[31:0]), WBits'(32'h5D5D5D5D));

      run_load(7'b1111_111, -1, -1, 1, 1'b0);

      run_load(7'b0000_001, -1, 8'hFF, -1, 1'b0);
      check("req033_w", WBits'(W[31:0]), WBits'(32'h000F000F));

      run_load(7'b0000_111, 8'h89, -1, -1, 1'b0);
      check("req034_w", WBits'(W[7:0]), WBits'(8'h01));
      check("req034_err", WBits'(enc_err), WBits'(1'b1));

      // Restart after two bytes: the new load needs its full byte count.
      start_load(7'b0000_111);
      send_byte(rand_byte(1'b1), 0);
      send_byte(rand_byte(1'b1), 0);
      run_load(7'b0000_111, -1, -1, -1, 1'b1);

      // Reset in the middle of a load abandons it.
      start_load(7'b0010_111);
      send_byte(8'h02, 0);
      send_byte(8'h55, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_W", W, '0);
      check("midrst_outs", WBits'({byte_ready, busy, done, w_valid, enc_err}), '0);
      sb_q.delete();
      done_before = done_cnt;
      @(posedge clk); #1;
      rst_n = 1'b1;
      byte_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         byte_in = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      check("postrst_no_done", WBits'(done_cnt), WBits'(done_before));
      check("postrst_W", W, '0);
      check("postrst_w_valid", WBits'(w_valid), WBits'(1'b0));

      for (int t = 0; t < 10; t++)
         run_load(7'($urandom), -1, -1, -1, 1'($urandom_range(0, 1)));

      repeat (3) @(posedge clk);
      #1;
      check("pending_done", WBits'(sb_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
